// File: rtl/led_sequencer.sv
// Drives the 8-LED bank: debounced mode/pause buttons, a prescaled step engine
// and a four-mode pattern generator (COUNT, SCAN, BLINK, FILL).
module led_sequencer #(
  parameter int PRESCALE_BITS = 22,
  parameter int DEBOUNCE_BITS = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_pause,
  output logic [7:0] leds,
  output logic [1:0] mode,
  output logic       paused,
  output logic       step_tick
);

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_SCAN  = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_FILL  = 2'd3
  } mode_t;

  localparam logic [PRESCALE_BITS-1:0] PRE_ONE = {{(PRESCALE_BITS-1){1'b0}}, 1'b1};
  localparam logic [DEBOUNCE_BITS-1:0] DB_ONE  = {{(DEBOUNCE_BITS-1){1'b0}}, 1'b1};

  mode_t                    state;
  mode_t                    next_mode;
  logic [PRESCALE_BITS-1:0] prescaler;
  logic                     scan_up;
  logic                     tick;
  logic [7:0]               next_leds;
  logic                     next_dir;
  logic [7:0]               entry_leds;

  // Index 0 is the mode button, index 1 the pause button.
  logic [1:0]               btn_raw;
  logic [1:0]               sync1;
  logic [1:0]               sync2;
  logic [1:0]               level;
  logic [1:0]               level_d;
  logic [DEBOUNCE_BITS-1:0] db_cnt [2];
  logic [1:0]               press;
  logic                     mode_press;
  logic                     pause_press;

  assign btn_raw = {btn_pause, btn_mode};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1     <= '0;
      sync2     <= '0;
      level     <= '0;
      level_d   <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == '1) begin
          level[i]  <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_ONE;
        end
      end
    end
  end

  assign press       = level & ~level_d;
  assign mode_press  = press[0];
  assign pause_press = press[1];

  assign tick       = (prescaler == '1) && !paused;
  assign next_mode  = mode_t'(state + 2'd1);
  assign entry_leds = (next_mode == MODE_SCAN) ? 8'h01 : 8'h00;
  assign mode       = state;

  // SCAN flips direction as it lands on an end LED, so each end is lit for one step.
  always_comb begin
    next_leds = leds;
    next_dir  = scan_up;
    case (state)
      MODE_COUNT: next_leds = leds + 8'd1;
      MODE_SCAN: begin
        if (scan_up) begin
          next_leds = {leds[6:0], 1'b0};
          if (leds[6]) next_dir = 1'b0;
        end else begin
          next_leds = {1'b0, leds[7:1]};
          if (leds[1]) next_dir = 1'b1;
        end
      end
      MODE_BLINK: next_leds = ~leds;
      MODE_FILL:  next_leds = (leds == 8'hFF) ? 8'h00 : {leds[6:0], 1'b1};
      default:    next_leds = leds;
    endcase
  end

  // A mode press outranks a coincident tick; pause toggling is independent of both.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= MODE_COUNT;
      leds      <= 8'h00;
      paused    <= 1'b0;
      step_tick <= 1'b0;
      prescaler <= '0;
      scan_up   <= 1'b1;
    end else begin
      step_tick <= 1'b0;
      if (pause_press) paused <= ~paused;
      if (mode_press) begin
        state     <= next_mode;
        prescaler <= '0;
        leds      <= entry_leds;
        scan_up   <= 1'b1;
      end else if (tick) begin
        leds      <= next_leds;
        scan_up   <= next_dir;
        prescaler <= '0;
        step_tick <= 1'b1;
      end else if (!paused) begin
        prescaler <= prescaler + PRE_ONE;
      end
    end
  end

endmodule

// File: tb/tb_led_sequencer.sv
// Scoreboard bench for led_sequencer with an 8-cycle step and 4-cycle debounce.
module tb_led_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_pause;
  logic [7:0] leds;
  logic [1:0] mode;
  logic       paused;
  logic       step_tick;

  logic [9:0] expQ [$];
  logic [9:0] expVal;
  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int lastTick = -1;
  int prevTick = -1;
  int tickCount = 0;
  int modeChangeCycle = -1;
  int pauseChangeCycle = -1;
  logic [1:0] lastMode = 2'd0;
  logic lastPaused = 1'b0;

  int c0, t0, savedTicks;

  led_sequencer #(.PRESCALE_BITS(3), .DEBOUNCE_BITS(2)) dut (
    .clk(clk),
    .reset(reset),
    .btn_mode(btn_mode),
    .btn_pause(btn_pause),
    .leds(leds),
    .mode(mode),
    .paused(paused),
    .step_tick(step_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every step_tick pops one expected {mode, leds} from the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (mode !== lastMode) modeChangeCycle = cycle;
      if (paused !== lastPaused) pauseChangeCycle = cycle;
      if (step_tick === 1'b1) begin
        prevTick = lastTick;
        lastTick = cycle;
        tickCount++;
        vectors++;
        if (expQ.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected_tick: got mode=%0d leds=%h, want no step_tick", mode, leds);
        end else begin
          expVal = expQ.pop_front();
          if ({mode, leds} !== expVal) begin
            miscompares++;
            $display("[TB] FAIL tick_pattern: got mode=%0d leds=%h, want mode=%0d leds=%h",
                     mode, leds, expVal[9:8], expVal[7:0]);
          end
        end
      end
    end
    lastMode   = mode;
    lastPaused = paused;
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic pushExp(input logic [1:0] m, input logic [7:0] l);
    expQ.push_back({m, l});
  endtask

  // which = 0 drives btn_mode, 1 drives btn_pause, held for 'hold' cycles.
  task automatic applyStimulus(input int which, input int hold);
    if (which == 0) btn_mode = 1'b1;
    else            btn_pause = 1'b1;
    repeat (hold) @(negedge clk);
    #1;
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (expQ.size() != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain_timeout: got %0d pending, want 0", expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset     = 1'b1;
    btn_mode  = 1'b0;
    btn_pause = 1'b0;
    waitCycles(3);
    checkOutput("reset_leds", leds, 8'h00);
    checkOutput("reset_state", {mode, paused, step_tick}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    c0 = cycle;

    $display("[TB] count mode, first five steps");
    for (int i = 1; i <= 5; i++) pushExp(2'd0, 8'(i));
    waitDrain(60);
    checkOutput("first_ticks_phase", lastTick, c0 + 40);
    checkOutput("tick_period", lastTick - prevTick, 8);

    waitCycles(3);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("midrun_reset_leds", leds, 8'h00);
    checkOutput("midrun_reset_mode", {mode, paused, step_tick}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    c0 = cycle;

    $display("[TB] count wrap through FF");
    for (int i = 1; i <= 257; i++) pushExp(2'd0, 8'(i));
    waitDrain(257 * 8 + 20);
    checkOutput("count_wrap_phase", lastTick, c0 + 257 * 8);

    $display("[TB] scan mode");
    t0 = lastTick;
    applyStimulus(0, 8);
    checkOutput("scan_mode", mode, 2'd1);
    checkOutput("scan_entry", leds, 8'h01);
    checkOutput("scan_press_cycle", modeChangeCycle, t0 + 7);
    pushExp(2'd1, 8'h02); pushExp(2'd1, 8'h04); pushExp(2'd1, 8'h08); pushExp(2'd1, 8'h10);
    pushExp(2'd1, 8'h20); pushExp(2'd1, 8'h40); pushExp(2'd1, 8'h80); pushExp(2'd1, 8'h40);
    pushExp(2'd1, 8'h20); pushExp(2'd1, 8'h10); pushExp(2'd1, 8'h08); pushExp(2'd1, 8'h04);
    pushExp(2'd1, 8'h02); pushExp(2'd1, 8'h01); pushExp(2'd1, 8'h02); pushExp(2'd1, 8'h04);
    waitDrain(16 * 8 + 20);
    checkOutput("scan_phase", lastTick, t0 + 7 + 128);

    $display("[TB] glitch then real mode press");
    pushExp(2'd1, 8'h08);
    pushExp(2'd1, 8'h10);
    applyStimulus(0, 3);
    waitCycles(6);
    checkOutput("glitch_ignored", mode, 2'd1);
    waitDrain(30);
    t0 = lastTick;
    applyStimulus(0, 8);
    checkOutput("blink_mode", mode, 2'd2);
    checkOutput("blink_entry", leds, 8'h00);
    checkOutput("blink_press_cycle", modeChangeCycle, t0 + 7);
    pushExp(2'd2, 8'hFF);
    pushExp(2'd2, 8'h00);
    waitDrain(40);
    checkOutput("restart_first_tick", prevTick, t0 + 15);
    checkOutput("restart_second_tick", lastTick, t0 + 23);

    $display("[TB] pause and resume");
    t0 = lastTick;
    pushExp(2'd2, 8'hFF);
    waitCycles(4);
    applyStimulus(1, 6);
    waitCycles(1);
    checkOutput("paused_set", paused, 1'b1);
    checkOutput("pause_cycle", pauseChangeCycle, t0 + 11);
    savedTicks = tickCount;
    waitCycles(100);
    checkOutput("paused_no_ticks", tickCount - savedTicks, 0);
    checkOutput("paused_leds_frozen", leds, 8'hFF);
    pushExp(2'd2, 8'h00);
    applyStimulus(1, 6);
    waitCycles(1);
    checkOutput("resumed", paused, 1'b0);
    waitDrain(30);
    checkOutput("resume_phase", lastTick, pauseChangeCycle + 5);

    $display("[TB] mode press aligned with tick, fill mode");
    t0 = lastTick;
    waitCycles(1);
    applyStimulus(0, 6);
    waitCycles(1);
    checkOutput("aligned_mode", mode, 2'd3);
    checkOutput("aligned_entry", leds, 8'h00);
    checkOutput("aligned_no_tick", step_tick, 1'b0);
    checkOutput("aligned_cycle", modeChangeCycle, t0 + 8);
    pushExp(2'd3, 8'h01); pushExp(2'd3, 8'h03); pushExp(2'd3, 8'h07);
    pushExp(2'd3, 8'h0F); pushExp(2'd3, 8'h1F); pushExp(2'd3, 8'h3F);
    pushExp(2'd3, 8'h7F); pushExp(2'd3, 8'hFF); pushExp(2'd3, 8'h00);
    waitDrain(100);
    checkOutput("fill_phase", lastTick, t0 + 8 + 72);

    $display("[TB] mode wrap back to count");
    applyStimulus(0, 8);
    checkOutput("wrap_mode", mode, 2'd0);
    checkOutput("wrap_entry", leds, 8'h00);
    pushExp(2'd0, 8'h01);
    waitDrain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
